// File: rtl/alu_vector_driver.sv
// -----------------------------------------------------------------------------
// alu_vector_driver
//
// Purpose:
//   Self-test driver for an external combinational 32-bit ALU. A small table
//   of test vectors {command, operandA, operandB, expected result, expected
//   flags} is written while idle. A run then applies each vector to the ALU,
//   waits SETTLE cycles, samples the ALU outputs and scores the vector as a
//   pass or a fail. The index of the first failing vector is retained.
//
// Configuration macro:
//   ALU_FLAG_CHECK_EN - when defined, a vector passes only if both the result
//                       and {carryout, zero, overflow} match. When undefined,
//                       only the result is compared and the stored flags are
//                       ignored.
//
// Parameters:
//   ADDR_W - vector index width
//   DEPTH  - number of vector slots, must equal 2**ADDR_W
//   SETTLE - idle cycles (>= 1) between driving a vector and sampling the ALU
//
// Ports:
//   clk, reset_n        - clock (rising edge), asynchronous active-low reset
//   wr_en .. wr_exp_*   - write one vector slot (accepted only while idle)
//   num_vectors, start  - run length (clamped to DEPTH) and run trigger
//   alu_command/operand - registered drives into the ALU
//   alu_result/flags    - combinational ALU outputs
//   busy, done          - run in progress / one-cycle end-of-run pulse
//   pass_count, fail_count, first_fail_idx, first_fail_valid - run results
// -----------------------------------------------------------------------------
module alu_vector_driver #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_cmd,
  input  logic [31:0]       wr_a,
  input  logic [31:0]       wr_b,
  input  logic [31:0]       wr_exp_result,
  input  logic [2:0]        wr_exp_flags,
  input  logic [ADDR_W:0]   num_vectors,
  input  logic              start,
  output logic [2:0]        alu_command,
  output logic [31:0]       alu_operandA,
  output logic [31:0]       alu_operandB,
  input  logic [31:0]       alu_result,
  input  logic              alu_carryout,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pass_count,
  output logic [ADDR_W:0]   fail_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic              first_fail_valid
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  WAIT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic [2:0]  exp_flags;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  vec_t mem [DEPTH];

  state_e state_q, state_d;

  // NOTE: the vector table has no reset; its contents are only meaningful
  // after software writes them, and leaving it out of reset keeps it a plain
  // RAM-style array.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem[wr_addr] <= '{cmd:        wr_cmd,
                        a:          wr_a,
                        b:          wr_b,
                        exp_result: wr_exp_result,
                        exp_flags:  wr_exp_flags};
    end
  end

  // ---------------------------------------------------------------------------
  // Run state
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [2:0]        alu_command_q, alu_command_d;
  logic [31:0]       alu_operand_a_q, alu_operand_a_d;
  logic [31:0]       alu_operand_b_q, alu_operand_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   pass_count_q, pass_count_d;
  logic [ADDR_W:0]   fail_count_q, fail_count_d;
  logic [ADDR_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic              first_fail_valid_q, first_fail_valid_d;

  vec_t cur_vec;
  logic vec_match;

  assign cur_vec = mem[idx_q];

`ifdef ALU_FLAG_CHECK_EN
  assign vec_match = (alu_result == cur_vec.exp_result) &&
                     ({alu_carryout, alu_zero, alu_overflow} == cur_vec.exp_flags);
`else
  // Flags are stored but play no part in scoring in this build.
  logic flags_unused;
  assign vec_match    = (alu_result == cur_vec.exp_result);
  assign flags_unused = ^{alu_carryout, alu_zero, alu_overflow, cur_vec.exp_flags};
`endif

  // NOTE: every signal gets its hold value first so that no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    count_d            = count_q;
    wait_d             = wait_q;
    alu_command_d      = alu_command_q;
    alu_operand_a_d    = alu_operand_a_q;
    alu_operand_b_d    = alu_operand_b_q;
    pass_count_d       = pass_count_q;
    fail_count_d       = fail_count_q;
    first_fail_idx_d   = first_fail_idx_q;
    first_fail_valid_d = first_fail_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d            = (num_vectors > CNT_DEPTH) ? CNT_DEPTH : num_vectors;
          idx_d              = '0;
          pass_count_d       = '0;
          fail_count_d       = '0;
          first_fail_idx_d   = '0;
          first_fail_valid_d = 1'b0;
          state_d            = (num_vectors == '0) ? S_DONE : S_DRIVE;
        end
      end

      S_DRIVE: begin
        alu_command_d   = cur_vec.cmd;
        alu_operand_a_d = cur_vec.a;
        alu_operand_b_d = cur_vec.b;
        wait_d          = CNT_W'(SETTLE);
        state_d         = S_WAIT;
      end

      S_WAIT: begin
        wait_d = wait_q - WAIT_ONE;
        // The counter enters at SETTLE, so the last wait cycle sees 1.
        if (wait_q <= WAIT_ONE) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (vec_match) begin
          pass_count_d = pass_count_q + CNT_ONE;
        end else begin
          fail_count_d = fail_count_q + CNT_ONE;
          if (!first_fail_valid_q) begin
            first_fail_idx_d   = idx_q;
            first_fail_valid_d = 1'b1;
          end
        end
        if ({1'b0, idx_q} == (count_q - CNT_ONE)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      idx_q              <= '0;
      count_q            <= '0;
      wait_q             <= '0;
      alu_command_q      <= '0;
      alu_operand_a_q    <= '0;
      alu_operand_b_q    <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_count_q       <= '0;
      fail_count_q       <= '0;
      first_fail_idx_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      count_q            <= count_d;
      wait_q             <= wait_d;
      alu_command_q      <= alu_command_d;
      alu_operand_a_q    <= alu_operand_a_d;
      alu_operand_b_q    <= alu_operand_b_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_count_q       <= pass_count_d;
      fail_count_q       <= fail_count_d;
      first_fail_idx_q   <= first_fail_idx_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign alu_command      = alu_command_q;
  assign alu_operandA     = alu_operand_a_q;
  assign alu_operandB     = alu_operand_b_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass_count       = pass_count_q;
  assign fail_count       = fail_count_q;
  assign first_fail_idx   = first_fail_idx_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_alu_vector_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_vector_driver
//
// Directed bench for alu_vector_driver. A behavioural 32-bit ALU sits on the
// driver's alu_* ports. Cycle numbers count rising edges after the edge that
// samples start; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_vector_driver;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 2;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_cmd;
  logic [31:0]       wr_a;
  logic [31:0]       wr_b;
  logic [31:0]       wr_exp_result;
  logic [2:0]        wr_exp_flags;
  logic [ADDR_W:0]   num_vectors;
  logic              start;
  logic [2:0]        alu_command;
  logic [31:0]       alu_operandA;
  logic [31:0]       alu_operandB;
  logic [31:0]       alu_result;
  logic              alu_carryout;
  logic              alu_zero;
  logic              alu_overflow;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   pass_count;
  logic [ADDR_W:0]   fail_count;
  logic [ADDR_W-1:0] first_fail_idx;
  logic              first_fail_valid;

  int n_checks = 0;
  int n_fail   = 0;

  alu_vector_driver #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_cmd           (wr_cmd),
    .wr_a             (wr_a),
    .wr_b             (wr_b),
    .wr_exp_result    (wr_exp_result),
    .wr_exp_flags     (wr_exp_flags),
    .num_vectors      (num_vectors),
    .start            (start),
    .alu_command      (alu_command),
    .alu_operandA     (alu_operandA),
    .alu_operandB     (alu_operandB),
    .alu_result       (alu_result),
    .alu_carryout     (alu_carryout),
    .alu_zero         (alu_zero),
    .alu_overflow     (alu_overflow),
    .busy             (busy),
    .done             (done),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .first_fail_idx   (first_fail_idx),
    .first_fail_valid (first_fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 000 ADD, 001 SUB, 010 SLT, 011 XOR, 100 AND, 101 NAND,
  // 110 NOR, 111 OR.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_result   = '0;
    alu_carryout = 1'b0;
    alu_overflow = 1'b0;
    case (alu_command)
      3'b000: begin
        alu_sum      = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        alu_result   = alu_sum[31:0];
        alu_carryout = alu_sum[32];
        alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_sum[31] != alu_operandA[31]);
      end
      3'b001: begin
        alu_sum      = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
        alu_result   = alu_sum[31:0];
        alu_carryout = alu_sum[32];
        alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_sum[31] != alu_operandA[31]);
      end
      3'b010:  alu_result = {31'd0, ($signed(alu_operandA) < $signed(alu_operandB))};
      3'b011:  alu_result = alu_operandA ^ alu_operandB;
      3'b100:  alu_result = alu_operandA & alu_operandB;
      3'b101:  alu_result = ~(alu_operandA & alu_operandB);
      3'b110:  alu_result = ~(alu_operandA | alu_operandB);
      default: alu_result = alu_operandA | alu_operandB;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_slot(input logic [ADDR_W-1:0] addr, input logic [2:0] cmd,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic [2:0] exp_flg);
    @(negedge clk);
    wr_en         = 1'b1;
    wr_addr       = addr;
    wr_cmd        = cmd;
    wr_a          = a;
    wr_b          = b;
    wr_exp_result = exp_res;
    wr_exp_flags  = exp_flg;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a run and waits for done. Optionally writes with start, disturbs
  // the run at a given cycle, or asserts reset at a given cycle (0 = never).
  task automatic run(input logic [ADDR_W:0] n, input bit wr_with_start,
                     input int disturb_at, input int reset_at,
                     output int done_cycle, output int busy_cycles);
    bit seen;
    done_cycle  = -1;
    busy_cycles = 0;
    @(negedge clk);
    num_vectors = n;
    start       = 1'b1;
    wr_en       = wr_with_start;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k == disturb_at) begin
        start         = 1'b1;
        wr_en         = 1'b1;
        wr_addr       = '0;
        wr_cmd        = 3'b111;
        wr_a          = 32'h0000_1234;
        wr_b          = 32'h0;
        wr_exp_result = 32'h0;
        wr_exp_flags  = 3'b111;
      end else if (k == disturb_at + 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (k == reset_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy",    32'(busy), 32'd0);
        check("rst_mid_done",    32'(done), 32'd0);
        check("rst_mid_pass",    32'(pass_count), 32'd0);
        check("rst_mid_fail",    32'(fail_count), 32'd0);
        check("rst_mid_ffvalid", 32'(first_fail_valid), 32'd0);
        check("rst_mid_cmd",     32'(alu_command), 32'd0);
        check("rst_mid_opa",     alu_operandA, 32'd0);
        check("rst_mid_opb",     alu_operandB, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
          @(negedge clk);
          if (done || busy) seen = 1'b1;
        end
        check("rst_mid_no_done", 32'(seen), 32'd0);
        return;
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_cycle = k;
        break;
      end
      @(negedge clk);
    end
    if (done_cycle < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int bc;
    reset_n       = 1'b0;
    start         = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_cmd        = '0;
    wr_a          = '0;
    wr_b          = '0;
    wr_exp_result = '0;
    wr_exp_flags  = '0;
    num_vectors   = '0;
    #2;
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_pass",    32'(pass_count), 32'd0);
    check("rst_fail",    32'(fail_count), 32'd0);
    check("rst_ffidx",   32'(first_fail_idx), 32'd0);
    check("rst_ffvalid", 32'(first_fail_valid), 32'd0);
    check("rst_cmd",     32'(alu_command), 32'd0);
    check("rst_opa",     alu_operandA, 32'd0);
    check("rst_opb",     alu_operandB, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: slot0 ADD with carry, slot1 SLT, slots 2..15 ADD i+i.
    write_slot(4'd0, 3'b000, 32'hefff_ffff, 32'hefff_ffff, 32'hdfff_fffe, 3'b100);
    write_slot(4'd1, 3'b010, 32'd1, 32'd2, 32'd1, 3'b000);
    for (int i = 2; i < DEPTH; i++)
      write_slot(ADDR_W'(i), 3'b000, 32'(i), 32'(i), 32'(2 * i), 3'b000);

    // Basic run.
    run(5'd2, 1'b0, 0, 0, dc, bc);
    check("basic_done_cycle", 32'(dc), 32'd9);
    check("basic_busy_cycles", 32'(bc), 32'd9);
    check("basic_pass", 32'(pass_count), 32'd2);
    check("basic_fail", 32'(fail_count), 32'd0);
    check("basic_ffvalid", 32'(first_fail_valid), 32'd0);
    check("basic_hold_cmd", 32'(alu_command), 32'd2);
    check("basic_hold_opa", alu_operandA, 32'd1);
    check("basic_hold_opb", alu_operandB, 32'd2);

    // Result mismatch on slot1.
    write_slot(4'd1, 3'b010, 32'd1, 32'd2, 32'd0, 3'b000);
    run(5'd2, 1'b0, 0, 0, dc, bc);
    check("mism_done_cycle", 32'(dc), 32'd9);
    check("mism_pass", 32'(pass_count), 32'd1);
    check("mism_fail", 32'(fail_count), 32'd1);
    check("mism_ffidx", 32'(first_fail_idx), 32'd1);
    check("mism_ffvalid", 32'(first_fail_valid), 32'd1);

    // Two mismatches: first index must stick at 1.
    write_slot(4'd3, 3'b000, 32'd3, 32'd3, 32'd7, 3'b000);
    run(5'd4, 1'b0, 0, 0, dc, bc);
    check("mism2_done_cycle", 32'(dc), 32'd17);
    check("mism2_pass", 32'(pass_count), 32'd2);
    check("mism2_fail", 32'(fail_count), 32'd2);
    check("mism2_ffidx", 32'(first_fail_idx), 32'd1);
    write_slot(4'd1, 3'b010, 32'd1, 32'd2, 32'd1, 3'b000);
    write_slot(4'd3, 3'b000, 32'd3, 32'd3, 32'd6, 3'b000);

    // Empty run clears the counters left over from the previous run.
    run(5'd0, 1'b0, 0, 0, dc, bc);
    check("empty_done_cycle", 32'(dc), 32'd1);
    check("empty_busy_cycles", 32'(bc), 32'd1);
    check("empty_pass", 32'(pass_count), 32'd0);
    check("empty_fail", 32'(fail_count), 32'd0);
    check("empty_ffvalid", 32'(first_fail_valid), 32'd0);

    // Oversized count clamps to DEPTH: 1 + 16*4 = 65.
    run(5'd31, 1'b0, 0, 0, dc, bc);
    check("clamp_done_cycle", 32'(dc), 32'd65);
    check("clamp_pass", 32'(pass_count), 32'd16);
    check("clamp_fail", 32'(fail_count), 32'd0);

    // start and wr_en during a run are ignored.
    run(5'd2, 1'b0, 3, 0, dc, bc);
    check("ign_done_cycle", 32'(dc), 32'd9);
    check("ign_pass", 32'(pass_count), 32'd2);
    run(5'd2, 1'b0, 0, 0, dc, bc);
    check("ign_slot0_kept", 32'(pass_count), 32'd2);

    // Write together with start: run sees the new (bad) slot0.
    wr_addr       = 4'd0;
    wr_cmd        = 3'b000;
    wr_a          = 32'hefff_ffff;
    wr_b          = 32'hefff_ffff;
    wr_exp_result = 32'h0;
    wr_exp_flags  = 3'b100;
    run(5'd1, 1'b1, 0, 0, dc, bc);
    check("wrstart_done_cycle", 32'(dc), 32'd5);
    check("wrstart_fail", 32'(fail_count), 32'd1);
    check("wrstart_ffidx", 32'(first_fail_idx), 32'd0);

    // Flag-only mismatch on slot0.
    write_slot(4'd0, 3'b000, 32'hefff_ffff, 32'hefff_ffff, 32'hdfff_fffe, 3'b000);
    run(5'd2, 1'b0, 0, 0, dc, bc);
`ifdef ALU_FLAG_CHECK_EN
    check("flag_pass", 32'(pass_count), 32'd1);
    check("flag_fail", 32'(fail_count), 32'd1);
    check("flag_ffidx", 32'(first_fail_idx), 32'd0);
`else
    check("flag_pass", 32'(pass_count), 32'd2);
    check("flag_fail", 32'(fail_count), 32'd0);
`endif
    write_slot(4'd0, 3'b000, 32'hefff_ffff, 32'hefff_ffff, 32'hdfff_fffe, 3'b100);

    // Reset during WAIT of vector 1, then a fresh run.
    run(5'd2, 1'b0, 0, 6, dc, bc);
    run(5'd2, 1'b0, 0, 0, dc, bc);
    check("post_rst_done_cycle", 32'(dc), 32'd9);
    check("post_rst_pass", 32'(pass_count), 32'd2);
    check("post_rst_fail", 32'(fail_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
